// File: rtl/fpa_adder.sv
// Half-precision (binary16) adder, one registered stage, RNE rounding, ovf/unf flags.
// Define SUBNORMAL_EN for gradual underflow; otherwise subnormals flush to zero.
module fpa_adder #(
  parameter logic [15:0] NAN_CODE = 16'h7E00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] Finput1,
  input  logic [15:0] Finput2,
  output logic [15:0] FPSUM,
  output logic        ovf,
  output logic        unf
);

  function automatic logic [3:0] lzc14(input logic [13:0] v);
    logic [3:0] c;
    c = 4'd14;
    for (int i = 0; i < 14; i++)
      if (v[i]) c = 4'(13 - i);
    return c;
  endfunction

  logic        sa, sb;
  logic [4:0]  ra, rb;
  logic [9:0]  fa, fb;
  logic        nan_a, nan_b, inf_a, inf_b;
  logic [4:0]  xa_e, xb_e;
  logic [10:0] xa_m, xb_m;
  logic        swap, ls, ss, sub;
  logic [4:0]  le, se, d;
  logic [10:0] lm, sm;
  logic [24:0] wide;
  logic [13:0] am, bs, n;
  logic [14:0] s;
  logic [3:0]  lz, sh;
  logic signed [6:0] ex, en, ef;
  logic        rup, tiny;
  logic [11:0] rm;
  logic [9:0]  fr;
  logic [15:0] res;
  logic        o, u;
`ifdef SUBNORMAL_EN
  logic [4:0]  lim;
`endif

  always_comb begin
    sa = Finput1[15];
    ra = Finput1[14:10];
    fa = Finput1[9:0];
    sb = Finput2[15];
    rb = Finput2[14:10];
    fb = Finput2[9:0];
    nan_a = (&ra) & (|fa);
    nan_b = (&rb) & (|fb);
    inf_a = (&ra) & ~(|fa);
    inf_b = (&rb) & ~(|fb);
`ifdef SUBNORMAL_EN
    xa_e = (ra == 5'd0) ? 5'd1 : ra;
    xb_e = (rb == 5'd0) ? 5'd1 : rb;
    xa_m = {|ra, fa};
    xb_m = {|rb, fb};
`else
    xa_e = ra;
    xb_e = rb;
    xa_m = (ra == 5'd0) ? 11'd0 : {1'b1, fa};
    xb_m = (rb == 5'd0) ? 11'd0 : {1'b1, fb};
`endif
    swap = {xb_e, xb_m} > {xa_e, xa_m};
    ls = swap ? sb : sa;
    ss = swap ? sa : sb;
    le = swap ? xb_e : xa_e;
    se = swap ? xa_e : xb_e;
    lm = swap ? xb_m : xa_m;
    sm = swap ? xa_m : xb_m;
    sub = ls ^ ss;
    d = le - se;
    wide = '0;
    // far-shifted operand survives only as sticky
    if (d >= 5'd13) begin
      bs = {13'd0, |sm};
    end else begin
      wide = {sm, 14'd0} >> d;
      bs = {wide[24:12], |wide[11:0]};
    end
    am = {lm, 3'b000};
    s = sub ? ({1'b0, am} - {1'b0, bs})
            : ({1'b0, am} + {1'b0, bs});
    lz = lzc14(s[13:0]);
    ex = $signed({2'b00, le});
`ifdef SUBNORMAL_EN
    lim = le - 5'd1;
    sh = ({1'b0, lz} > lim) ? lim[3:0] : lz;
`else
    sh = lz;
`endif
    if (s[14]) begin
      n = {s[14:2], s[1] | s[0]};
      en = ex + 7'sd1;
    end else begin
      n = s[13:0] << sh;
      en = ex - $signed({3'b000, sh});
    end
    rup = n[2] & (n[1] | n[0] | n[3]);
    rm = {1'b0, n[13:3]} + {11'd0, rup};
    if (rm[11]) begin
      fr = rm[10:1];
      ef = en + 7'sd1;
    end else begin
      fr = rm[9:0];
      ef = en;
    end
`ifdef SUBNORMAL_EN
    tiny = ~rm[11] & ~rm[10];
`else
    tiny = en < 7'sd1;
`endif
    res = '0;
    o = 1'b0;
    u = 1'b0;
    if (nan_a | nan_b | (inf_a & inf_b & (sa ^ sb))) begin
      res = NAN_CODE;
    end else if (inf_a) begin
      res = {sa, 5'h1F, 10'd0};
    end else if (inf_b) begin
      res = {sb, 5'h1F, 10'd0};
    end else if (s == 15'd0) begin
      res = {sa & sb, 15'd0};
    end else if (tiny) begin
      u = 1'b1;
`ifdef SUBNORMAL_EN
      res = {ls, 5'd0, fr};
`else
      res = {ls, 15'd0};
`endif
    end else if (ef >= 7'sd31) begin
      o = 1'b1;
      res = {ls, 5'h1F, 10'd0};
    end else begin
      res = {ls, ef[4:0], fr};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FPSUM <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      FPSUM <= res;
      ovf   <= o;
      unf   <= u;
    end
  end

endmodule

// File: tb/tb_fpa_adder.sv
// Scoreboard bench for fpa_adder: directed vectors, queued expectations.
// Honours SUBNORMAL_EN for the tiny-result expectation.
module tb_fpa_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [15:0] FPSUM;
  logic        ovf, unf;

  fpa_adder dut (
    .clk(clk),
    .rst_n(rst_n),
    .Finput1(a),
    .Finput2(b),
    .FPSUM(FPSUM),
    .ovf(ovf),
    .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] fp;
    logic        o;
    logic        u;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   vid = 0;

  task automatic check(input string nm, input logic [17:0] act,
                       input logic [17:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got sum=%h ovf=%b unf=%b, required sum=%h ovf=%b unf=%b",
               nm, act[17:2], act[1], act[0], req[17:2], req[1], req[0]);
    end
  endtask

  task automatic issue(input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] fp, input logic o,
                       input logic u);
    exp_t e;
    @(negedge clk);
    a = x;
    b = y;
    e.id = vid;
    e.fp = fp;
    e.o = o;
    e.u = u;
    exp_q.push_back(e);
    vid++;
  endtask

  exp_t got;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      check($sformatf("vec%0d", got.id), {FPSUM, ovf, unf},
            {got.fp, got.o, got.u});
    end
  end

  initial begin
    exp_t e;
    #1 rst_n = 1'b0;
    #7;
    check("reset_state", {FPSUM, ovf, unf}, 18'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(16'h3C00, 16'h3C00, 16'h4000, 1'b0, 1'b0);
    issue(16'h4200, 16'hC000, 16'h3C00, 1'b0, 1'b0);
    issue(16'h3C00, 16'hBC00, 16'h0000, 1'b0, 1'b0);
    issue(16'h8000, 16'h8000, 16'h8000, 1'b0, 1'b0);
    issue(16'h0000, 16'h3555, 16'h3555, 1'b0, 1'b0);
    issue(16'h3555, 16'h0000, 16'h3555, 1'b0, 1'b0);
    issue(16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b0);
    issue(16'h7BFF, 16'h7BFF, 16'h7C00, 1'b1, 1'b0);
    issue(16'hFBFF, 16'hFBFF, 16'hFC00, 1'b1, 1'b0);
    issue(16'h7C00, 16'h3C00, 16'h7C00, 1'b0, 1'b0);
    issue(16'hFC00, 16'h3C00, 16'hFC00, 1'b0, 1'b0);
    issue(16'h7C00, 16'h7C00, 16'h7C00, 1'b0, 1'b0);
    issue(16'h7C00, 16'hFC00, 16'h7E00, 1'b0, 1'b0);
    issue(16'h7E00, 16'h3C00, 16'h7E00, 1'b0, 1'b0);
    issue(16'h3C00, 16'h1400, 16'h3C01, 1'b0, 1'b0);
    issue(16'h3C00, 16'h1000, 16'h3C00, 1'b0, 1'b0);
    issue(16'h3C01, 16'h1000, 16'h3C02, 1'b0, 1'b0);
    issue(16'h3C00, 16'h0400, 16'h3C00, 1'b0, 1'b0);
    issue(16'h3C00, 16'hC000, 16'hBC00, 1'b0, 1'b0);
`ifdef SUBNORMAL_EN
    issue(16'h0400, 16'h8401, 16'h8001, 1'b0, 1'b1);
`else
    issue(16'h0400, 16'h8401, 16'h8000, 1'b0, 1'b1);
`endif
    issue(16'h3C00, 16'h3C00, 16'h4000, 1'b0, 1'b0);

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", {FPSUM, ovf, unf}, 18'd0);
    @(posedge clk);
    #1;
    check("reset_hold", {FPSUM, ovf, unf}, 18'd0);
    @(negedge clk);
    rst_n = 1'b1;
    e.id = vid;
    e.fp = 16'h4000;
    e.o = 1'b0;
    e.u = 1'b0;
    exp_q.push_back(e);
    vid++;

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(negedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0",
               exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
